// File: rtl/pacman_dir_encoder.sv
// Button front end: sync + debounce four buttons, resolve a sticky one-hot move direction, emit game-step strobe.
// Optional PACMAN_DIR_BUFFER_EN latches debounced rising edges so taps shorter than a tick still steer.
module pacman_dir_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 1666666
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rbtn,
  input  logic       lbtn,
  input  logic       ubtn,
  input  logic       dbtn,
  output logic [3:0] move_dir,
  output logic       move_tick,
  output logic [3:0] btn_state
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

  logic [3:0]      w_raw;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [DB_W-1:0] r_db_cnt [4];
  logic [3:0]      r_btn_state;
  logic [3:0]      w_mismatch;
  logic [3:0]      w_toggle;
  logic [TK_W-1:0] r_tick_cnt;
  logic            w_tick_edge;
  logic [3:0]      w_req;
  logic [3:0]      w_dir;
  logic [3:0]      r_move_dir;
  logic            r_move_tick;

  assign w_raw = {dbtn, ubtn, lbtn, rbtn};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A button flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    w_mismatch = r_sync2 ^ r_btn_state;
    w_toggle   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_toggle[i] = w_mismatch[i] && (r_db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_state <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!w_mismatch[i] || w_toggle[i]) begin
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
        if (w_toggle[i]) begin
          r_btn_state[i] <= ~r_btn_state[i];
        end
      end
    end
  end

  assign w_tick_edge = (r_tick_cnt == TK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick_edge) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TK_W'(1);
    end
  end

`ifdef PACMAN_DIR_BUFFER_EN
  logic [3:0] r_pending;
  logic [3:0] w_rise;

  assign w_rise = w_toggle & ~r_btn_state;
  assign w_req  = r_btn_state | r_pending;

  // An edge landing on the tick cycle survives into the next period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 4'b0000;
    end else if (w_tick_edge) begin
      r_pending <= w_rise;
    end else begin
      r_pending <= r_pending | w_rise;
    end
  end
`else
  assign w_req = r_btn_state;
`endif

  // Priority up > down > left > right; no request keeps the last direction.
  always_comb begin
    w_dir = r_move_dir;
    if (w_req[2]) begin
      w_dir = 4'b0100;
    end else if (w_req[3]) begin
      w_dir = 4'b1000;
    end else if (w_req[1]) begin
      w_dir = 4'b0010;
    end else if (w_req[0]) begin
      w_dir = 4'b0001;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_move_dir  <= 4'b0000;
      r_move_tick <= 1'b0;
    end else begin
      r_move_tick <= w_tick_edge;
      if (w_tick_edge) begin
        r_move_dir <= w_dir;
      end
    end
  end

  assign move_dir  = r_move_dir;
  assign move_tick = r_move_tick;
  assign btn_state = r_btn_state;

endmodule

// File: tb/tb_pacman_dir_encoder.sv
// Directed + randomized bench for pacman_dir_encoder with a window/arithmetic reference model.
module tb_pacman_dir_encoder;
  localparam int D = 4;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rbtn = 1'b0, lbtn = 1'b0, ubtn = 1'b0, dbtn = 1'b0;
  logic [3:0] move_dir;
  logic       move_tick;
  logic [3:0] btn_state;

  int checks = 0;
  int errors = 0;

  pacman_dir_encoder #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
    .clk(clk), .rst(rst_n), .rbtn(rbtn), .lbtn(lbtn), .ubtn(ubtn), .dbtn(dbtn),
    .move_dir(move_dir), .move_tick(move_tick), .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  // Reference model: synced sample = raw sampled two edges earlier; a level flips
  // once the last D synced samples all disagree with it; ticks every T-th edge.
  logic [3:0] m_state, m_dir, m_pend;
  logic       m_tick;
  int         m_n;
  logic [3:0] m_raw_q[$];
  logic [3:0] m_syn_q[$];

  task automatic model_reset();
    m_state = 4'b0; m_dir = 4'b0; m_pend = 4'b0; m_tick = 1'b0; m_n = 0;
    m_raw_q.delete(); m_syn_q.delete();
  endtask

  task automatic model_edge();
    logic [3:0] syn, req, nstate, rise;
    logic tk;
    bit all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    syn = (m_raw_q.size() >= 2) ? m_raw_q[m_raw_q.size()-2] : 4'b0;
    m_raw_q.push_back({dbtn, ubtn, lbtn, rbtn});
    if (m_raw_q.size() > 2) void'(m_raw_q.pop_front());
    m_syn_q.push_back(syn);
    if (m_syn_q.size() > D) void'(m_syn_q.pop_front());
`ifdef PACMAN_DIR_BUFFER_EN
    req = m_state | m_pend;
`else
    req = m_state;
`endif
    m_n++;
    tk = ((m_n % T) == 0);
    if (tk) begin
      if (req[2])      m_dir = 4'b0100;
      else if (req[3]) m_dir = 4'b1000;
      else if (req[1]) m_dir = 4'b0010;
      else if (req[0]) m_dir = 4'b0001;
    end
    nstate = m_state;
    for (int b = 0; b < 4; b++) begin
      all_diff = (m_syn_q.size() >= D);
      foreach (m_syn_q[k]) if (m_syn_q[k][b] == m_state[b]) all_diff = 0;
      if (all_diff) nstate[b] = ~m_state[b];
    end
    rise = nstate & ~m_state;
    m_pend = tk ? rise : (m_pend | rise);
    m_state = nstate;
    m_tick = tk;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("btn_state", btn_state, m_state);
    check("move_dir", move_dir, m_dir);
    check("move_tick", {3'b0, move_tick}, {3'b0, m_tick});
    check("onehot", {3'b0, ($countones(move_dir) <= 1)}, 4'b0001);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    int ntick;
    int first;
    model_reset();

    // 1: reset held while buttons toggle
    repeat (20) begin
      {dbtn, ubtn, lbtn, rbtn} = 4'($urandom_range(0, 15));
      cyc(1);
    end
    check("rst_dir", move_dir, 4'b0000);
    check("rst_state", btn_state, 4'b0000);

    // 2: up held -> debounced after D+2 edges, then ticks every T
    {dbtn, ubtn, lbtn, rbtn} = 4'b0000;
    rst_n = 1'b1;
    cyc(9);
    ubtn = 1'b1;
    cyc(D + 1);
    check("up_not_yet", {3'b0, btn_state[2]}, 4'b0000);
    cyc(1);
    check("up_debounced", {3'b0, btn_state[2]}, 4'b0001);
    ntick = 0;
    for (int i = 0; i < 2 * T; i++) begin
      cyc(1);
      if (move_tick) ntick++;
    end
    check("tick_rate", 4'(ntick), 4'd2);
    check("up_dir", move_dir, 4'b0100);
    ubtn = 1'b0;
    cyc(2 * T);
    check("up_sticky", move_dir, 4'b0100);

    // 3: short right pulses are filtered
    for (int i = 0; i < 10; i++) begin
      rbtn = 1'b1; cyc(2);
      rbtn = 1'b0; cyc(2);
    end
    check("glitch_state", btn_state, 4'b0000);
    check("glitch_dir", move_dir, 4'b0100);

    // 4: simultaneous left+down, then release down, then release all
    lbtn = 1'b1; dbtn = 1'b1;
    cyc(2 * T + D);
    check("down_wins", move_dir, 4'b1000);
    dbtn = 1'b0;
    cyc(2 * T);
    check("left_after", move_dir, 4'b0010);
    lbtn = 1'b0;
    cyc(2 * T);
    check("left_sticky", move_dir, 4'b0010);

    // 5: right debounced high only between two ticks
    for (int i = 0; i < T && (m_n % T) != 4; i++) cyc(1);
    rbtn = 1'b1;
    cyc(D);
    rbtn = 1'b0;
    cyc(T);
`ifdef PACMAN_DIR_BUFFER_EN
    check("tap_dir", move_dir, 4'b0001);
`else
    check("tap_dir", move_dir, 4'b0010);
`endif
    cyc(T);

    // 6: async reset mid-count, first tick T edges after release
    ubtn = 1'b1;
    cyc(3 * T);
    check("pre_rst_dir", move_dir, 4'b0100);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_dir", move_dir, 4'b0000);
    check("async_tick", {3'b0, move_tick}, 4'b0000);
    check("async_state", btn_state, 4'b0000);
    cyc(3);
    rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 3 * T && first == 0; k++) begin
      cyc(1);
      if (move_tick) first = k;
    end
    check("first_tick", 4'(first), 4'(T));
    ubtn = 1'b0;

    // 7: random hold lengths with occasional resets
    for (int s = 0; s < 150; s++) begin
      {dbtn, ubtn, lbtn, rbtn} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        rst_n = 1'b1;
      end
      cyc($urandom_range(1, 14));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
